muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. It sits

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the MIPS controller and the multiply/divide unit.
// The controller side drives the request; the unit returns status, HI/LO and the mfhi/mflo read data.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output start, funct, a, b,
        input  busy, done, hi, lo, rd_data
    );

    modport slave (
        input  start, funct, a, b,
        output busy, done, hi, lo, rd_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Each multiply or divide takes one shift-add or restoring step per cycle on operand magnitudes.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        op_signed = SIGNED_EN && (bus.funct == F_MULT || bus.funct == F_DIV);
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
        b_mag     = b_neg ? ({WIDTH{1'b0}} - bus.b) : bus.b;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = rem_shift - {1'b0, mcand_q};
        prod      = neg_res_q ? ({(2*WIDTH){1'b0}} - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
        quot      = neg_res_q ? ({WIDTH{1'b0}} - acc_lo_q) : acc_lo_q;
        rem       = neg_rem_q ? ({WIDTH{1'b0}} - acc_hi_q) : acc_hi_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            // Divide keeps the divisor in mcand and shifts dividend bits out of acc_lo.
                            is_div_d  = bus.funct[1];
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = (bus.b == {WIDTH{1'b0}});
                            mcand_d   = bus.funct[1] ? b_mag : a_mag;
                            acc_lo_d  = bus.funct[1] ? a_mag : b_mag;
                            acc_hi_d  = {WIDTH{1'b0}};
                            cnt_d     = CNT_W'(WIDTH);
                            state_d   = S_CALC;
                        end
                        F_MTHI:  hi_d = bus.a;
                        F_MTLO:  lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                // A zero divisor leaves the dividend in the remainder; only the quotient needs forcing.
                if (is_div_q) begin
                    lo_d = div0_q ? {WIDTH{1'b1}} : quot;
                    hi_d = rem;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = (bus.funct == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference arithmetic model fills a scoreboard queue
// at issue time and each done pulse pops and compares HI/LO.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results straight from SV integer arithmetic.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        e  = '0;
        case (f)
            F_MULT: begin
                sp = longint'(sx) * longint'(sy);
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            F_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            F_DIV: begin
                if (y == 32'h0) begin
                    e.lo = 32'hFFFFFFFF;
                    e.hi = x;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000;
                    e.hi = 32'h0;
                end else begin
                    e.lo = sx / sy;
                    e.hi = sx % sy;
                end
            end
            default: begin
                if (y == 32'h0) begin
                    e.lo = 32'hFFFFFFFF;
                    e.hi = x;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = x;
        bus.b     = y;
        if (push) sb.push_back(model(f, x, y));
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_start observed=%b expected=1", bus.busy);
        end
    endtask

    task automatic wait_done(input string name, input bit inject, output int lat);
        exp_t e;
        bit   seen;
        bit   busy_ok;
        seen    = 1'b0;
        busy_ok = 1'b1;
        lat     = -1;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (inject && (n == 5 || n == 6)) begin
                    bus.start = 1'b1;
                    bus.funct = F_MULT;
                end else if (inject && (n == 7 || n == 8)) begin
                    bus.start = 1'b1;
                    bus.funct = F_MTHI;
                end else begin
                    bus.start = 1'b0;
                end
                bus.a = $urandom;
                bus.b = $urandom;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_timeout observed=no_done expected=done_within_100", name);
        end else begin
            checks++;
            if (!busy_ok) begin
                errors++;
                $display("[TB] FAIL %s_busy_hold observed=dropped expected=held", name);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s_unexpected_done observed=done expected=no_pending", name);
            end else begin
                e = sb.pop_front();
                if (bus.hi !== e.hi) begin
                    errors++;
                    $display("[TB] FAIL %s_hi observed=%h expected=%h", name, bus.hi, e.hi);
                end
                checks++;
                if (bus.lo !== e.lo) begin
                    errors++;
                    $display("[TB] FAIL %s_lo observed=%h expected=%h", name, bus.lo, e.lo);
                end
            end
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string name, input bit inject);
        int lat;
        issue(f, x, y, 1'b1);
        wait_done(name, inject, lat);
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("[TB] FAIL %s_latency observed=%0d expected=%0d", name, lat, W + 1);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_after_done observed=done%b_busy%b expected=done0_busy0",
                     name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.funct = 6'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags observed=busy%b_done%b expected=busy0_done0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_hilo observed=%h_%h expected=0_0", bus.hi, bus.lo);
        end
    endtask

    task automatic test_move();
        bus.start = 1'b1;
        bus.funct = F_MTHI;
        bus.a     = 32'hAAAA5555;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'hAAAA5555 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mthi observed=hi%h_busy%b_done%b expected=hiaaaa5555_busy0_done0",
                     bus.hi, bus.busy, bus.done);
        end
        bus.funct = F_MTLO;
        bus.a     = 32'h12345678;
        @(negedge clk);
        checks++;
        if (bus.lo !== 32'h12345678 || bus.hi !== 32'hAAAA5555 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mtlo observed=hi%h_lo%h_busy%b expected=hiaaaa5555_lo12345678_busy0",
                     bus.hi, bus.lo, bus.busy);
        end
        bus.funct = 6'b111111;
        bus.a     = 32'hFFFF0000;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'hAAAA5555 || bus.lo !== 32'h12345678 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_funct observed=hi%h_lo%h_busy%b expected=unchanged_busy0",
                     bus.hi, bus.lo, bus.busy);
        end
        bus.funct = F_MFHI;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.rd_data !== 32'hAAAA5555 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mfhi_read observed=%h_busy%b expected=aaaa5555_busy0", bus.rd_data, bus.busy);
        end
        bus.funct = F_MFLO;
        #1;
        checks++;
        if (bus.rd_data !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL mflo_read observed=%h expected=12345678", bus.rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op(F_MULTU, 32'd7, 32'd6, "multu_7x6", 1'b0);
        run_op(F_MULT, 32'hFFFFFFFD, 32'd5, "mult_m3x5", 1'b0);
        run_op(F_MULT, 32'h80000000, 32'h80000000, "mult_minmin", 1'b0);
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_maxmax", 1'b0);
    endtask

    task automatic test_div();
        run_op(F_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, "div_m7_2", 1'b0);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow", 1'b0);
        run_op(F_DIVU, 32'h1234, 32'd0, "divu_by_zero", 1'b0);
        run_op(F_DIV, 32'hFFFFFFF9, 32'd0, "div_by_zero", 1'b0);
        run_op(F_DIV, 32'd7, 32'hFFFFFFFE, "div_7_m2", 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op(F_DIVU, 32'hDEADBEEF, 32'd13, "div_start_ignored", 1'b1);
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(F_MULTU, 32'd9, 32'd9, 1'b1);
        wait_done("b2b_first", 1'b0, lat);
        bus.start = 1'b1;
        bus.funct = F_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        sb.push_back(model(F_DIVU, 32'd1000, 32'd3));
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_edge_ignored observed=busy%b expected=busy0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept observed=busy%b expected=busy1", bus.busy);
        end
        wait_done("b2b_second", 1'b0, lat);
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("[TB] FAIL b2b_latency observed=%0d expected=%0d", lat, W + 1);
        end
        @(negedge clk);
        run_op(F_MULT, 32'hFFFFFFFF, 32'd2, "b2b_third", 1'b0);
    endtask

    task automatic test_random();
        logic [5:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            x = $urandom;
            y = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 300));
            run_op(f, x, y, "random", 1'b0);
        end
    endtask

    task automatic test_reset_abort();
        bit pulse;
        bus.start = 1'b1;
        bus.funct = F_MTHI;
        bus.a     = 32'h55555555;
        @(negedge clk);
        bus.funct = F_MTLO;
        @(negedge clk);
        bus.start = 1'b0;
        issue(F_DIV, 32'd5000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_reset observed=busy%b_hi%h_lo%h expected=busy0_hi0_lo0",
                     bus.busy, bus.hi, bus.lo);
        end
        pulse = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.done !== 1'b0) pulse = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("[TB] FAIL abort_no_done observed=done_pulse expected=none");
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
